sm_ram_arbiter: RTL

//  Shares the single-port data RAM between two masters: m0 = CPU load/store

---
 rtl/sm_ram_arbiter_pkg.sv | 13 +
 rtl/sm_ram_arbiter_if.sv | 34 +++
 rtl/sm_arb_rr2.sv | 32 +++
 rtl/sm_ram_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/sm_ram_arbiter_pkg.sv
// Shared types and default sizes for the data-RAM arbiter and its picker.
package sm_ram_arbiter_pkg;

    localparam int unsigned ARB_AW    = 6;
    localparam int unsigned ARB_DW    = 32;
    localparam int unsigned ARB_CNT_W = 16;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_id_e;

endpackage

// File: rtl/sm_ram_arbiter_if.sv
// Master-side access port and RAM-macro port of the data-RAM arbiter.
interface sm_ram_arbiter_if
    import sm_ram_arbiter_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt_c;
    logic          rvalid;
    logic [DW-1:0] rdata_c;

    modport master (output req, we, addr, wdata, input gnt_c, rvalid, rdata_c);
    modport slave  (input req, we, addr, wdata, output gnt_c, rvalid, rdata_c);
endinterface

interface sm_ram_mem_if
    import sm_ram_arbiter_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
);
    logic          en_c;
    logic          we_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;
    logic [DW-1:0] rdata;

    modport ctrl (output en_c, we_c, addr_c, wdata_c, input rdata);
    modport mem  (input en_c, we_c, addr_c, wdata_c, output rdata);
endinterface

// File: rtl/sm_arb_rr2.sv
// Two-way round-robin picker: a tie goes to the master that did not win last.
module sm_arb_rr2
    import sm_ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_id_e    last_gnt_i,
    output logic [1:0] gnt_c_o,
    output arb_id_e    idx_c_o
);

    always_comb begin
        gnt_c_o = 2'b00;
        idx_c_o = ARB_M0;
        unique case (req_i)
            2'b01: gnt_c_o = 2'b01;
            2'b10: begin
                gnt_c_o = 2'b10;
                idx_c_o = ARB_M1;
            end
            2'b11: begin
                if (last_gnt_i == ARB_M0) begin
                    gnt_c_o = 2'b10;
                    idx_c_o = ARB_M1;
                end else begin
                    gnt_c_o = 2'b01;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sm_ram_arbiter.sv
// Shares the single-port data RAM between the CPU (m0) and debug/DMA (m1) ports;
// one access per cycle, read data routed back to its requester one cycle later.
module sm_ram_arbiter
    import sm_ram_arbiter_pkg::*;
#(
    parameter int unsigned AW    = ARB_AW,
    parameter int unsigned DW    = ARB_DW,
    parameter int unsigned CNT_W = ARB_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_ram_arbiter_if.slave   m0_if,
    sm_ram_arbiter_if.slave   m1_if,
    sm_ram_mem_if.ctrl        ram_if,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    logic [1:0]       req_c;
    logic [1:0]       gnt_c;
    arb_id_e          idx_c;
    logic             ram_we_c;
    logic [AW-1:0]    ram_addr_c;
    logic [DW-1:0]    ram_wdata_c;

    arb_id_e          last_gnt_q, last_gnt_d;
    logic             rd_pend_q,  rd_pend_d;
    arb_id_e          rd_src_q,   rd_src_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             rvalid0,    rvalid1;

    assign req_c = {m1_if.req, m0_if.req};

    sm_arb_rr2 u_pick (
        .req_i      (req_c),
        .last_gnt_i (last_gnt_q),
        .gnt_c_o    (gnt_c),
        .idx_c_o    (idx_c)
    );

    assign m0_if.gnt_c = gnt_c[0];
    assign m1_if.gnt_c = gnt_c[1];

    // Only the granted master's fields reach the RAM; idle cycles park on m0.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_addr_c  = m0_if.addr;
        ram_wdata_c = m0_if.wdata;
        if (gnt_c[1]) begin
            ram_we_c    = m1_if.we;
            ram_addr_c  = m1_if.addr;
            ram_wdata_c = m1_if.wdata;
        end else if (gnt_c[0]) begin
            ram_we_c    = m0_if.we;
        end
    end

    assign ram_if.en_c    = |gnt_c;
    assign ram_if.we_c    = ram_we_c;
    assign ram_if.addr_c  = ram_addr_c;
    assign ram_if.wdata_c = ram_wdata_c;

    always_comb begin
        last_gnt_d = last_gnt_q;
        rd_pend_d  = 1'b0;
        rd_src_d   = rd_src_q;
        cnt_d      = cnt_q;
        if (|gnt_c) begin
            last_gnt_d = idx_c;
            rd_pend_d  = ~ram_we_c;
            rd_src_d   = idx_c;
        end
        if ((&req_c) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= ARB_M1;
            rd_pend_q  <= 1'b0;
            rd_src_q   <= ARB_M0;
            cnt_q      <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_src_q   <= rd_src_d;
            cnt_q      <= cnt_d;
        end
    end

    // Response demux: the RAM output is visible only to the master that read.
    assign rvalid0 = rd_pend_q & (rd_src_q == ARB_M0);
    assign rvalid1 = rd_pend_q & (rd_src_q == ARB_M1);

    assign m0_if.rvalid  = rvalid0;
    assign m1_if.rvalid  = rvalid1;
    assign m0_if.rdata_c = rvalid0 ? ram_if.rdata : '0;
    assign m1_if.rdata_c = rvalid1 ? ram_if.rdata : '0;

    assign conflict_cnt_o = cnt_q;

endmodule
